sr_frame_deserializer: RTL and testbench

Serial-to-parallel receiver for the single-wire shift-register stream: it takes the bit stream that our serial shift register drives out on `sr_out`, frames it, and reassembles N-bit words. Frames use an idle-low line, a single high start bit, N data bits and a low stop bit. Bit order is selectable per frame through `control`, matching the shift direction used on the transmit side. Each completed word is presented on a parallel bus with a one-cycle valid strobe, and malformed frames are flagged.

---
 rtl/sr_frame_deserializer_if.sv | 30 +++
 rtl/sr_frame_deserializer.sv | 86 ++++++++
 tb/tb_sr_frame_deserializer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sr_frame_deserializer_if.sv
// Handshake bundle between the serial line side and the parallel word side
// of the frame deserializer.
interface sr_frame_deserializer_if #(
    parameter int N = 8
);
    logic         sr_in;
    logic         control;
    logic [N-1:0] data;
    logic         data_valid;
    logic         frame_err;
    logic         busy;

    modport master (
        output sr_in,
        output control,
        input  data,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  sr_in,
        input  control,
        output data,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/sr_frame_deserializer.sv
// Frames the idle-low shift-register stream (start=1, N data, stop=0)
// and reassembles N-bit words in the bit order chosen at the start bit.
module sr_frame_deserializer #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    sr_frame_deserializer_if.slave   bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    shreg;
    logic            order_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.sr_in) state_n = DATA;
            DATA: if (cnt == CW'(N - 1)) state_n = STOP;
            STOP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == DATA) || (state == STOP);
    end

    // Datapath registers; the strobes default low so each lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= '0;
            shreg          <= '0;
            order_q        <= 1'b0;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.sr_in) begin
                        order_q <= bus.control;
                        cnt     <= '0;
                        shreg   <= '0;
                    end
                end
                DATA: begin
                    cnt <= cnt + CW'(1);
                    if (order_q) begin
                        shreg <= {shreg[N-2:0], bus.sr_in};
                    end else begin
                        shreg <= {bus.sr_in, shreg[N-1:1]};
                    end
                end
                STOP: begin
                    if (bus.sr_in) begin
                        bus.frame_err <= 1'b1;
                    end else begin
                        bus.data       <= shreg;
                        bus.data_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_frame_deserializer.sv
// Directed bench for sr_frame_deserializer: bit order, framing errors,
// back-to-back frames and synchronous reset behaviour.
module tb_sr_frame_deserializer;
    localparam int N = 8;

    logic clk;
    logic reset;

    sr_frame_deserializer_if #(.N(N)) bus ();

    sr_frame_deserializer #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int busy_cnt = 0;
    int vcnt = 0;
    int ecnt = 0;
    int vt_last = 0;
    int vt_prev = 0;
    logic [N-1:0] vd[$];

    // Observe outputs 1 time unit after each active edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.busy) busy_cnt++;
        if (bus.frame_err) ecnt++;
        if (bus.data_valid) begin
            vcnt++;
            vt_prev = vt_last;
            vt_last = cyc;
            vd.push_back(bus.data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic c);
        @(negedge clk);
        bus.sr_in   = s;
        bus.control = c;
    endtask

    // seq[N-1] is the first data bit on the line.
    task automatic send(input logic c, input logic [N-1:0] seq,
                        input logic stop, input bit flip);
        logic cc;
        cc = c;
        drive(1'b1, c);
        for (int i = N - 1; i >= 0; i--) begin
            if (flip) cc = ~cc;
            drive(seq[i], cc);
        end
        drive(stop, cc);
    endtask

    int b0, v0, e0;

    initial begin
        reset       = 1'b1;
        bus.sr_in   = 1'b1;
        bus.control = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_data",  32'(bus.data), 32'h0);
        check("rst_valid", 32'(bus.data_valid), 32'h0);
        check("rst_err",   32'(bus.frame_err), 32'h0);
        check("rst_busy",  32'(bus.busy), 32'h0);
        reset     = 1'b0;
        bus.sr_in = 1'b0;

        // MSB first A5, one-cycle valid, 9 busy cycles
        b0 = busy_cnt;
        v0 = vcnt;
        send(1'b1, 8'hA5, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("msb_a5_data",  32'(bus.data), 32'hA5);
        check("msb_a5_valid", 32'(bus.data_valid), 32'h1);
        check("msb_a5_busy",  32'(bus.busy), 32'h0);
        drive(1'b0, 1'b0);
        check("msb_a5_valid_1cyc", 32'(bus.data_valid), 32'h0);
        check("msb_a5_busy_cycles", 32'(busy_cnt - b0), 32'd9);
        check("msb_a5_pulses", 32'(vcnt - v0), 32'd1);

        // LSB first
        send(1'b0, 8'hA5, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("lsb_a5_data", 32'(bus.data), 32'hA5);
        send(1'b0, 8'hC0, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("lsb_c0_data",  32'(bus.data), 32'h03);
        check("lsb_c0_valid", 32'(bus.data_valid), 32'h1);
        send(1'b1, 8'hC0, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("msb_c0_data", 32'(bus.data), 32'hC0);

        // control toggling mid-frame is ignored
        send(1'b1, 8'h96, 1'b0, 1'b1);
        drive(1'b0, 1'b0);
        check("toggle_data", 32'(bus.data), 32'h96);

        // bad stop bit keeps old data
        send(1'b1, 8'h3C, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("good_3c_data", 32'(bus.data), 32'h3C);
        e0 = ecnt;
        send(1'b1, 8'hFF, 1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("err_pulse", 32'(bus.frame_err), 32'h1);
        check("err_no_valid", 32'(bus.data_valid), 32'h0);
        check("err_data_kept", 32'(bus.data), 32'h3C);
        check("err_idle", 32'(bus.busy), 32'h0);
        drive(1'b0, 1'b0);
        check("err_1cyc", 32'(bus.frame_err), 32'h0);
        check("err_no_restart", 32'(bus.busy), 32'h0);
        check("err_count", 32'(ecnt - e0), 32'd1);

        // back-to-back frames, no dead cycle
        v0 = vcnt;
        send(1'b1, 8'h12, 1'b0, 1'b0);
        send(1'b1, 8'h34, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("b2b_pulses", 32'(vcnt - v0), 32'd2);
        if (vcnt - v0 == 2) begin
            check("b2b_first",  32'(vd[v0]), 32'h12);
            check("b2b_second", 32'(vd[v0+1]), 32'h34);
        end
        check("b2b_spacing", 32'(vt_last - vt_prev), 32'd10);

        // synchronous reset after 4 data bits, line held high
        v0 = vcnt;
        e0 = ecnt;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        @(negedge clk);
        reset     = 1'b1;
        bus.sr_in = 1'b1;
        @(negedge clk);
        check("mid_rst_data",  32'(bus.data), 32'h0);
        check("mid_rst_busy",  32'(bus.busy), 32'h0);
        check("mid_rst_valid", 32'(bus.data_valid), 32'h0);
        check("mid_rst_err",   32'(bus.frame_err), 32'h0);
        reset     = 1'b0;
        bus.sr_in = 1'b0;
        repeat (12) drive(1'b0, 1'b0);
        check("mid_rst_no_valid", 32'(vcnt - v0), 32'd0);
        check("mid_rst_no_err",   32'(ecnt - e0), 32'd0);
        check("mid_rst_idle",     32'(bus.busy), 32'h0);
        send(1'b1, 8'h5A, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("post_rst_data", 32'(bus.data), 32'h5A);

        // reset pulse between edges has no effect, even mid-frame
        drive(1'b0, 1'b0);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        check("glitch_idle_data", 32'(bus.data), 32'h5A);
        drive(1'b1, 1'b1);
        for (int i = N - 1; i >= 0; i--) begin
            logic [N-1:0] w;
            w = 8'hE7;
            drive(w[i], 1'b1);
            if (i == 4) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        check("glitch_frame_data",  32'(bus.data), 32'hE7);
        check("glitch_frame_valid", 32'(bus.data_valid), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
